// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60Hz raster timing generator.
// Divides clk down to a pixel strobe, walks hCount/vCount across the raster,
// registers sync and blanked colour with one pixel of latency, and emits
// frame-rate and game-rate strobes for clk-domain game logic.
module vga_timing_gen #(
   parameter int unsigned PIX_DIV  = 4,
   parameter int unsigned H_TOTAL  = 800,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_VIS_LO = 144,
   parameter int unsigned H_VIS_HI = 783,
   parameter int unsigned V_TOTAL  = 525,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_VIS_LO = 35,
   parameter int unsigned V_VIS_HI = 514,
   parameter int unsigned GAME_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] rgb_in,
   output logic        pix_en,
   output logic [9:0]  hCount,
   output logic [9:0]  vCount,
   output logic        bright,
   output logic        frame_tick,
   output logic        game_tick,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic [11:0] vga_rgb
);

   localparam int unsigned DIV_W  = (PIX_DIV  > 1) ? $clog2(PIX_DIV)  : 1;
   localparam int unsigned GAME_W = (GAME_DIV > 1) ? $clog2(GAME_DIV) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PIX_DIV - 1);
   localparam logic [GAME_W-1:0] GAME_LAST = GAME_W'(GAME_DIV - 1);
   localparam logic [9:0]        H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]        V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0]        H_SYNC_W  = 10'(H_SYNC);
   localparam logic [9:0]        V_SYNC_W  = 10'(V_SYNC);
   localparam logic [9:0]        H_LO      = 10'(H_VIS_LO);
   localparam logic [9:0]        H_HI      = 10'(H_VIS_HI);
   localparam logic [9:0]        V_LO      = 10'(V_VIS_LO);
   localparam logic [9:0]        V_HI      = 10'(V_VIS_HI);

   logic [DIV_W-1:0]  div_cnt;
   logic [GAME_W-1:0] frame_cnt;
   logic              h_last;
   logic              v_last;
   logic              hs_raw;
   logic              vs_raw;

   // Pixel strobe: last phase of the clock divider.
   always_comb begin
      pix_en = (div_cnt == DIV_LAST);
   end

   // Clock divider: counts 0..PIX_DIV-1, restarting on the strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (pix_en) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Raster end-of-line / end-of-frame detection.
   always_comb begin
      h_last = (hCount == H_LAST);
      v_last = (vCount == V_LAST);
   end

   // Raster counters: advance one pixel per strobe, wrap only at the terminal values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hCount <= '0;
         vCount <= '0;
      end else if (pix_en) begin
         if (h_last) begin
            hCount <= '0;
            if (v_last) begin
               vCount <= '0;
            end else begin
               vCount <= vCount + 1'b1;
            end
         end else begin
            hCount <= hCount + 1'b1;
         end
      end
   end

   // Visible window and raw active-low syncs for the current raster position.
   always_comb begin
      bright = (hCount >= H_LO) && (hCount <= H_HI) &&
               (vCount >= V_LO) && (vCount <= V_HI);
      hs_raw = (hCount >= H_SYNC_W);
      vs_raw = (vCount >= V_SYNC_W);
   end

   // Output pipeline: sync and blanked colour registered together so they stay aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_hs  <= 1'b1;
         vga_vs  <= 1'b1;
         vga_rgb <= '0;
      end else if (pix_en) begin
         vga_hs  <= hs_raw;
         vga_vs  <= vs_raw;
         vga_rgb <= bright ? rgb_in : 12'h000;
      end
   end

   // Frame strobe on the last pixel of the frame; game strobe on every GAME_DIV-th frame.
   always_comb begin
      frame_tick = pix_en && h_last && v_last;
      game_tick  = frame_tick && (frame_cnt == GAME_LAST);
   end

   // Frame counter: 0..GAME_DIV-1, advancing on each frame strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (frame_tick) begin
         if (frame_cnt == GAME_LAST) begin
            frame_cnt <= '0;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

endmodule
